stream_patchifier: RTL and testbench
====================================

STREAM_PATCHIFIER -- requirements
Module: stream_patchifier

Interface
REQ-001 SHALL have parameter CHANNEL_SIZE, default 8, bits per channel.
REQ-002 SHALL have parameter NUM_CHANNELS, default 3, channels per pixel; PIXEL_WIDTH = CHANNEL_SIZE*NUM_CHANNELS (derived).
REQ-003 SHALL have parameters IMG_WIDTH, default 64, and IMG_HEIGHT, default 64, image size in pixels.
REQ-004 SHALL have parameter PATCH_SIZE, default 4, patch edge in pixels; PATCH_VECTOR_SIZE = PATCH_SIZE*PATCH_SIZE.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1, frame start request, sampled only in IDLE.
REQ-008 SHALL have ports in_pixel (input, PIXEL_WIDTH), in_valid (input, 1) and in_ready (output, 1): raster-order pixel stream, row-major, top-left first.
REQ-009 SHALL have ports out_patch (output, PATCH_VECTOR_SIZE*PIXEL_WIDTH), out_valid (output, 1) and out_ready (input, 1): one flattened patch per transfer.
REQ-010 SHALL have port out_last, output, 1: high with the final patch of the frame.
REQ-011 SHALL have port state, output, 2: 00 IDLE, 01 FILL, 10 DRAIN.
REQ-012 SHALL have port done, output, 1: one-cycle pulse after the final patch transfer.

Function
REQ-013 SHALL fail elaboration ($error) unless IMG_WIDTH and IMG_HEIGHT are both multiples of PATCH_SIZE.
REQ-014 SHALL buffer one band of PATCH_SIZE rows x IMG_WIDTH pixels (single-buffered).
REQ-015 SHALL transition IDLE->FILL on en=1; en outside IDLE is ignored.
REQ-016 SHALL assert in_ready only in FILL; a pixel transfers when in_valid && in_ready.
REQ-017 SHALL write each accepted pixel to band[row_in_band][x]; x wraps at IMG_WIDTH-1, incrementing row_in_band.
REQ-018 SHALL transition FILL->DRAIN on the cycle the band's last pixel (row PATCH_SIZE-1, x IMG_WIDTH-1) is accepted; out_valid rises on the next cycle.
REQ-019 SHALL, in DRAIN, present patches for patch_col 0..IMG_WIDTH/PATCH_SIZE-1 in order, with out_valid=1 throughout.
REQ-020 SHALL place pixel (r,c) of the current patch at out_patch[(r*PATCH_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-021 SHALL hold out_patch, out_last and out_valid stable while out_valid && !out_ready.
REQ-022 SHALL advance patch_col only on out_valid && out_ready.
REQ-023 SHALL, after the band's last patch transfers, go to FILL if bands remain, else to IDLE with done=1 for exactly one cycle.
REQ-024 SHALL assert out_last only for band IMG_HEIGHT/PATCH_SIZE-1, patch_col IMG_WIDTH/PATCH_SIZE-1.
REQ-025 SHALL emit patches in patch-index order (band*PATCHES_IN_ROW + patch_col), TOTAL_NUM_PATCHES per frame.
REQ-026 SHALL not accept input in DRAIN or IDLE (in_ready=0); upstream back-pressure only stalls.

Reset
REQ-027 SHALL, on reset at any time including mid-frame, asynchronously force state=IDLE, in_ready=0, out_valid=0, out_last=0, done=0, and all counters to 0.
REQ-028 SHALL leave band-buffer contents undefined after reset; out_patch is don't-care while out_valid=0.

Configuration
REQ-029 SHALL, with macro STREAM_PATCHIFIER_PATCH_IDX_EN defined, add output out_patch_idx, width $clog2(TOTAL_NUM_PATCHES), equal to band*PATCHES_IN_ROW + patch_col, valid and stable with out_valid, reset value 0.
REQ-030 SHALL, without STREAM_PATCHIFIER_PATCH_IDX_EN, omit out_patch_idx and its logic; all other behaviour is identical.

Verification (IMG_WIDTH=IMG_HEIGHT=8, PATCH_SIZE=4, CHANNEL_SIZE=8, NUM_CHANNELS=1)
REQ-031 SHALL cover: en=1, 64 pixels with value = raster index, out_ready=1 -> 4 patches; patch 0 elements = {0,1,2,3,8,9,10,11,16,...,27}; patch 3 = {36..39,...,60..63}; out_last on patch 3; done pulses once.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles on patch 1 -> out_patch/out_valid unchanged, in_ready=0, patch_col stays 1.
REQ-033 SHALL cover: in_valid toggled every other cycle -> same patches as REQ-031; DRAIN entered only after pixel 31.
REQ-034 SHALL cover: reset asserted after pixel 20 -> state=00, out_valid=0 immediately; new frame then yields REQ-031 results.
REQ-035 SHALL cover: en=1 during FILL/DRAIN -> no effect; with STREAM_PATCHIFIER_PATCH_IDX_EN, out_patch_idx = 0,1,2,3.

Source files
------------

// File: rtl/stream_patchifier.sv
// Streams a raster image in and emits flattened PATCH_SIZE x PATCH_SIZE patches, one band of rows at a time.
// Optional macro STREAM_PATCHIFIER_PATCH_IDX_EN adds the out_patch_idx output.
module stream_patchifier #(
   parameter int CHANNEL_SIZE = 8,
   parameter int NUM_CHANNELS = 3,
   parameter int IMG_WIDTH    = 64,
   parameter int IMG_HEIGHT   = 64,
   parameter int PATCH_SIZE   = 4,
   localparam int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
   localparam int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE,
   localparam int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
   localparam int IDX_W             = (TOTAL_NUM_PATCHES > 1) ? $clog2(TOTAL_NUM_PATCHES) : 1
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic                                       en,
   input  logic [PIXEL_WIDTH-1:0]                     in_pixel,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   output logic [PATCH_VECTOR_SIZE*PIXEL_WIDTH-1:0]   out_patch,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic                                       out_last,
   output logic [1:0]                                 state,
   output logic                                       done
`ifdef STREAM_PATCHIFIER_PATCH_IDX_EN
   ,
   output logic [IDX_W-1:0]                           out_patch_idx
`endif
);

   localparam int PATCHES_IN_ROW = IMG_WIDTH / PATCH_SIZE;
   localparam int NUM_BANDS      = IMG_HEIGHT / PATCH_SIZE;
   localparam int X_W = (IMG_WIDTH > 1)      ? $clog2(IMG_WIDTH)      : 1;
   localparam int R_W = (PATCH_SIZE > 1)     ? $clog2(PATCH_SIZE)     : 1;
   localparam int C_W = (PATCHES_IN_ROW > 1) ? $clog2(PATCHES_IN_ROW) : 1;
   localparam int B_W = (NUM_BANDS > 1)      ? $clog2(NUM_BANDS)      : 1;

   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
   localparam logic [R_W-1:0] R_LAST = R_W'(PATCH_SIZE - 1);
   localparam logic [C_W-1:0] C_LAST = C_W'(PATCHES_IN_ROW - 1);
   localparam logic [B_W-1:0] B_LAST = B_W'(NUM_BANDS - 1);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_FILL  = 2'b01;
   localparam logic [1:0] S_DRAIN = 2'b10;

   generate
      if ((IMG_WIDTH % PATCH_SIZE) != 0 || (IMG_HEIGHT % PATCH_SIZE) != 0) begin : g_bad_geometry
         $error("stream_patchifier: IMG_WIDTH and IMG_HEIGHT must be multiples of PATCH_SIZE");
      end
   endgenerate

   logic [1:0]     state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [R_W-1:0] row_q, row_d;
   logic [B_W-1:0] band_idx_q, band_idx_d;
   logic [C_W-1:0] col_q, col_d;
   logic           done_q, done_d;
   logic           wr_en;
   logic [X_W-1:0] col_base;

   logic [PIXEL_WIDTH-1:0] band_mem [PATCH_SIZE][IMG_WIDTH];

   // Both ports use valid/ready: a beat moves on a rising edge where valid && ready;
   // valid-side contents stay stable while valid && !ready.
   assign in_ready  = (state_q == S_FILL);
   assign out_valid = (state_q == S_DRAIN);
   assign out_last  = out_valid && (band_idx_q == B_LAST) && (col_q == C_LAST);
   assign state     = state_q;
   assign done      = done_q;
   assign wr_en     = in_ready && in_valid;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      row_d      = row_q;
      band_idx_d = band_idx_q;
      col_d      = col_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d    = S_FILL;
               x_d        = '0;
               row_d      = '0;
               band_idx_d = '0;
               col_d      = '0;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               if (x_q == X_LAST) begin
                  x_d = '0;
                  if (row_q == R_LAST) begin
                     row_d   = '0;
                     state_d = S_DRAIN;
                  end else begin
                     row_d = row_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (col_q == C_LAST) begin
                  col_d = '0;
                  if (band_idx_q == B_LAST) begin
                     band_idx_d = '0;
                     state_d    = S_IDLE;
                     done_d     = 1'b1;
                  end else begin
                     band_idx_d = band_idx_q + 1'b1;
                     state_d    = S_FILL;
                  end
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         row_q      <= '0;
         band_idx_q <= '0;
         col_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         row_q      <= row_d;
         band_idx_q <= band_idx_d;
         col_q      <= col_d;
         done_q     <= done_d;
      end
   end

   // Band storage has no reset; contents are only observed after a full band is written.
   always_ff @(posedge clk) begin
      if (wr_en) band_mem[row_q][x_q] <= in_pixel;
   end

   assign col_base = X_W'(col_q) * X_W'(PATCH_SIZE);

   generate
      for (genvar r = 0; r < PATCH_SIZE; r++) begin : g_row
         for (genvar c = 0; c < PATCH_SIZE; c++) begin : g_col
            assign out_patch[(r*PATCH_SIZE+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = band_mem[r][col_base + X_W'(c)];
         end
      end
   endgenerate

`ifdef STREAM_PATCHIFIER_PATCH_IDX_EN
   assign out_patch_idx = IDX_W'(band_idx_q) * IDX_W'(PATCHES_IN_ROW) + IDX_W'(col_q);
`endif

endmodule

// File: tb/tb_stream_patchifier.sv
// Randomized bench for stream_patchifier on an 8x8 single-channel image with 4x4 patches,
// scoring every patch transfer and per-cycle handshake/state against a frame-level model.
module tb_stream_patchifier;

   localparam int W     = 8;
   localparam int H     = 8;
   localparam int P     = 4;
   localparam int PW    = 8;
   localparam int PVW   = P * P * PW;
   localparam int PIR   = W / P;
   localparam int TOTAL = PIR * (H / P);
   localparam int BAND  = P * W;

   logic            clk;
   logic            reset;
   logic            en;
   logic [PW-1:0]   in_pixel;
   logic            in_valid;
   logic            in_ready;
   logic [PVW-1:0]  out_patch;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;
   logic [1:0]      state;
   logic            done;
`ifdef STREAM_PATCHIFIER_PATCH_IDX_EN
   logic [1:0]      out_patch_idx;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [PVW-1:0] exp_q[$];

   stream_patchifier #(
      .CHANNEL_SIZE(8), .NUM_CHANNELS(1), .IMG_WIDTH(W), .IMG_HEIGHT(H), .PATCH_SIZE(P)
   ) dut (
      .clk(clk), .reset(reset), .en(en),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_patch(out_patch), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .state(state), .done(done)
`ifdef STREAM_PATCHIFIER_PATCH_IDX_EN
      , .out_patch_idx(out_patch_idx)
`endif
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [PVW-1:0] got, input logic [PVW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_state"}, state, 2'b00);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_last"}, out_last, 0);
      check({tag, "_done"}, done, 0);
   endtask

   // iv_mode: 0 always valid, 1 every other cycle, 2 random
   // rdy_mode: 0 always ready, 1 random, 2 hold ready low for 5 cycles on patch 1
   task automatic run_frame(input bit rand_pix, input int iv_mode, input int rdy_mode, input int abort_at);
      logic [PW-1:0]  img [W*H];
      logic [PVW-1:0] p;
      int  pix, pout, stall, cyc, done_cnt;
      bit  running, done_pend, exp_fill, exp_drain;

      for (int i = 0; i < W*H; i++) img[i] = rand_pix ? PW'($urandom) : PW'(i);
      exp_q.delete();
      for (int k = 0; k < TOTAL; k++) begin
         p = '0;
         for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++)
               p[(r*P+c)*PW +: PW] = img[((k/PIR)*P + r)*W + (k%PIR)*P + c];
         exp_q.push_back(p);
      end

      pix = 0; pout = 0; stall = 0; cyc = 0; done_cnt = 0; done_pend = 0;
      @(negedge clk);
      en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      running = 1;

      forever begin
         @(negedge clk);
         en = 1'b0;
         exp_fill  = running && (pix < (pout/PIR + 1) * BAND);
         exp_drain = running && !exp_fill;
         check("state", state, {exp_drain, exp_fill});
         check("in_ready", in_ready, exp_fill);
         check("out_valid", out_valid, exp_drain);
         check("out_last", out_last, exp_drain && (pout == TOTAL-1));
         check("done", done, done_pend);
         if (done === 1'b1) done_cnt++;
         if (exp_drain && exp_q.size() > 0) begin
            check("out_patch", out_patch, exp_q[0]);
`ifdef STREAM_PATCHIFIER_PATCH_IDX_EN
            check("out_patch_idx", out_patch_idx, pout);
`endif
         end
         if (!running) break;
         done_pend = 0;
         if (abort_at >= 0 && pix == abort_at) break;
         cyc++;
         if (cyc > 3000) begin
            check("frame_timeout", 1, 0);
            break;
         end

         case (iv_mode)
            0:       in_valid = 1'b1;
            1:       in_valid = (cyc % 2) == 0;
            default: in_valid = 1'($urandom_range(0, 1));
         endcase
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = !(pout == 1 && stall < 5);
         endcase
         if (rdy_mode == 2 && exp_drain && pout == 1 && !out_ready) stall++;
         en = ($urandom_range(0, 3) == 0);
         in_pixel = (pix < W*H) ? img[pix] : PW'($urandom);

         if (in_valid && exp_fill) pix++;
         if (out_ready && exp_drain) begin
            void'(exp_q.pop_front());
            pout++;
            if (pout == TOTAL) begin
               running   = 0;
               done_pend = 1;
            end
         end
      end

      en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      if (abort_at >= 0 && running) begin
         #2 reset = 1'b1;
         #1 check_idle("abort");
         @(negedge clk);
         reset = 1'b0;
         exp_q.delete();
      end else begin
         @(negedge clk);
         check("done_once", done_cnt, 1);
         check("done_low", done, 0);
         check("queue_empty", exp_q.size(), 0);
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      run_frame(0, 0, 0, -1);
      run_frame(0, 0, 2, -1);
      run_frame(0, 1, 0, -1);
      run_frame(1, 2, 1, 21);
      run_frame(0, 0, 0, -1);
      for (int f = 0; f < 4; f++) run_frame(1, 2, 1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
